// File: rtl/mixer_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mixer_ctrl_pkg : op codes, FSM encodings and gain helpers for mixer_ctrl |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package mixer_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SET_IN  = 2'd0,
    OP_SET_OUT = 2'd1,
    OP_SWAP    = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_IN   = 2'd1,
    R_OUT  = 2'd2
  } ramp_state_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RISE = 2'd2,
    S_WAIT_FALL = 2'd3
  } swap_state_e;

  // Unity gain in the mixer's fixed-point format (gain_shift integer bits above q1).
  function automatic int unsigned unity_gain(input int unsigned dw, input int unsigned gs);
    return 32'd1 << (dw - 1 - gs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_ctrl_gain_ramp_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gain_ramp_step : one bounded step of a gain toward its target            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module gain_ramp_step #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [DATA_WIDTH-1:0] next,
  output logic                  no_change
);

  logic [DATA_WIDTH:0] cur_w;
  logic [DATA_WIDTH:0] tgt_w;
  logic [DATA_WIDTH:0] step_w;
  logic [DATA_WIDTH:0] diff_w;
  logic [DATA_WIDTH:0] delta_w;
  logic [DATA_WIDTH:0] sum_w;
  logic                going_up;
  logic                unused_msb;

  // One guard bit keeps the difference and the stepped value from wrapping.
  always_comb begin
    cur_w     = {1'b0, cur};
    tgt_w     = {1'b0, target};
    step_w    = {1'b0, step};
    going_up  = (tgt_w > cur_w);
    no_change = (cur == target);
    diff_w    = going_up ? (tgt_w - cur_w) : (cur_w - tgt_w);
    delta_w   = (diff_w < step_w) ? diff_w : step_w;
    sum_w     = going_up ? (cur_w + delta_w) : (cur_w - delta_w);
    next      = sum_w[DATA_WIDTH-1:0];
  end

  assign unused_msb = sum_w[DATA_WIDTH];

endmodule
`default_nettype wire

// File: rtl/mixer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mixer_ctrl : gain-ramp and pipeline-swap sequencer in front of the mixer |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module mixer_ctrl
  import mixer_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int GAIN_SHIFT   = 4,
  parameter int RAMP_STEP    = 16,
  parameter int SWAP_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  sample_tick,
  input  logic                  pipelines_swapping,
  output logic [DATA_WIDTH-1:0] mixer_data,
  output logic                  set_input_gain,
  output logic                  set_output_gain,
  output logic                  swap_pipelines,
  output logic                  current_pipeline,
  output logic                  ramping,
  output logic                  cmd_error,
  output logic                  swap_fault
);

  localparam logic [DATA_WIDTH-1:0] c_unity = DATA_WIDTH'(unity_gain(DATA_WIDTH, GAIN_SHIFT));
  localparam logic [DATA_WIDTH-1:0] c_step  = DATA_WIDTH'(RAMP_STEP);
  localparam int                    c_cnt_w = $clog2(SWAP_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0]    c_tmo   = c_cnt_w'(SWAP_TIMEOUT);
  localparam logic [c_cnt_w-1:0]    c_one   = c_cnt_w'(1);

  ramp_state_e           ramp_state_q, ramp_state_d;
  swap_state_e           swap_state_q, swap_state_d;
  logic                  tick_pending_q, tick_pending_d;
  logic                  swap_pending_q, swap_pending_d;
  logic [DATA_WIDTH-1:0] in_cur_q, in_cur_d;
  logic [DATA_WIDTH-1:0] in_tgt_q, in_tgt_d;
  logic [DATA_WIDTH-1:0] out_cur_q, out_cur_d;
  logic [DATA_WIDTH-1:0] out_tgt_q, out_tgt_d;
  logic [DATA_WIDTH-1:0] mixer_data_q, mixer_data_d;
  logic                  set_in_q, set_in_d;
  logic                  set_out_q, set_out_d;
  logic                  swap_q, swap_d;
  logic                  cur_pipe_q, cur_pipe_d;
  logic                  ramping_q, ramping_d;
  logic                  cmd_error_q, cmd_error_d;
  logic                  swap_fault_q, swap_fault_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [c_cnt_w-1:0]    timer_q, timer_d;

  logic [DATA_WIDTH-1:0] in_next;
  logic [DATA_WIDTH-1:0] out_next;
  logic                  in_same;
  logic                  out_same;
  logic                  cmd_fire;

  gain_ramp_step #(.DATA_WIDTH(DATA_WIDTH)) u_in_step (
    .cur       (in_cur_q),
    .target    (in_tgt_q),
    .step      (c_step),
    .next      (in_next),
    .no_change (in_same)
  );

  gain_ramp_step #(.DATA_WIDTH(DATA_WIDTH)) u_out_step (
    .cur       (out_cur_q),
    .target    (out_tgt_q),
    .step      (c_step),
    .next      (out_next),
    .no_change (out_same)
  );

  assign cmd_fire = cmd_valid & cmd_ready_q;

  always_comb begin
    ramp_state_d   = ramp_state_q;
    swap_state_d   = swap_state_q;
    tick_pending_d = tick_pending_q;
    swap_pending_d = swap_pending_q;
    in_cur_d       = in_cur_q;
    in_tgt_d       = in_tgt_q;
    out_cur_d      = out_cur_q;
    out_tgt_d      = out_tgt_q;
    mixer_data_d   = mixer_data_q;
    set_in_d       = 1'b0;
    set_out_d      = 1'b0;
    swap_d         = 1'b0;
    cur_pipe_d     = cur_pipe_q;
    cmd_error_d    = 1'b0;
    swap_fault_d   = swap_fault_q;
    timer_d        = timer_q;

    // Ramp slots: the input slot is always followed by the output slot.
    case (ramp_state_q)
      R_IDLE: begin
        if (tick_pending_q) begin
          ramp_state_d   = R_IN;
          tick_pending_d = 1'b0;
        end
      end
      R_IN: begin
        if (!in_same) begin
          in_cur_d     = in_next;
          mixer_data_d = in_next;
          set_in_d     = 1'b1;
        end
        ramp_state_d = R_OUT;
      end
      R_OUT: begin
        if (!out_same) begin
          out_cur_d    = out_next;
          mixer_data_d = out_next;
          set_out_d    = 1'b1;
        end
        ramp_state_d = R_IDLE;
      end
      default: ramp_state_d = R_IDLE;
    endcase

    if (sample_tick) begin
      tick_pending_d = 1'b1;
    end

    case (swap_state_q)
      S_IDLE: begin
        if (swap_pending_q) begin
          swap_state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        swap_d         = 1'b1;
        cur_pipe_d     = ~cur_pipe_q;
        swap_pending_d = 1'b0;
        timer_d        = c_tmo;
        swap_state_d   = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (pipelines_swapping) begin
          swap_state_d = S_WAIT_FALL;
        end else if (timer_q == '0) begin
          swap_fault_d = 1'b1;
          swap_state_d = S_IDLE;
        end else begin
          timer_d = timer_q - c_one;
        end
      end
      S_WAIT_FALL: begin
        if (!pipelines_swapping) begin
          swap_state_d = S_IDLE;
        end
      end
      default: swap_state_d = S_IDLE;
    endcase

    // Commands are only accepted while no swap is pending, so they never
    // collide with the swap FSM clearing swap_pending.
    if (cmd_fire) begin
      case (op_e'(cmd_op))
        OP_SET_IN:  in_tgt_d       = cmd_data;
        OP_SET_OUT: out_tgt_d      = cmd_data;
        OP_SWAP:    swap_pending_d = 1'b1;
        default:    cmd_error_d    = 1'b1;
      endcase
    end

    cmd_ready_d = ~swap_pending_d;
    ramping_d   = (in_cur_d != in_tgt_d) | (out_cur_d != out_tgt_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_state_q   <= R_IDLE;
      swap_state_q   <= S_IDLE;
      tick_pending_q <= 1'b0;
      swap_pending_q <= 1'b0;
      in_cur_q       <= c_unity;
      in_tgt_q       <= c_unity;
      out_cur_q      <= c_unity;
      out_tgt_q      <= c_unity;
      mixer_data_q   <= '0;
      set_in_q       <= 1'b0;
      set_out_q      <= 1'b0;
      swap_q         <= 1'b0;
      cur_pipe_q     <= 1'b0;
      ramping_q      <= 1'b0;
      cmd_error_q    <= 1'b0;
      swap_fault_q   <= 1'b0;
      cmd_ready_q    <= 1'b1;
      timer_q        <= '0;
    end else begin
      ramp_state_q   <= ramp_state_d;
      swap_state_q   <= swap_state_d;
      tick_pending_q <= tick_pending_d;
      swap_pending_q <= swap_pending_d;
      in_cur_q       <= in_cur_d;
      in_tgt_q       <= in_tgt_d;
      out_cur_q      <= out_cur_d;
      out_tgt_q      <= out_tgt_d;
      mixer_data_q   <= mixer_data_d;
      set_in_q       <= set_in_d;
      set_out_q      <= set_out_d;
      swap_q         <= swap_d;
      cur_pipe_q     <= cur_pipe_d;
      ramping_q      <= ramping_d;
      cmd_error_q    <= cmd_error_d;
      swap_fault_q   <= swap_fault_d;
      cmd_ready_q    <= cmd_ready_d;
      timer_q        <= timer_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign mixer_data       = mixer_data_q;
  assign set_input_gain   = set_in_q;
  assign set_output_gain  = set_out_q;
  assign swap_pipelines   = swap_q;
  assign current_pipeline = cur_pipe_q;
  assign ramping          = ramping_q;
  assign cmd_error        = cmd_error_q;
  assign swap_fault       = swap_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mixer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mixer_ctrl : directed scoreboard bench for mixer_ctrl                 |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_mixer_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          sample_tick;
  logic          pipelines_swapping;
  logic [DW-1:0] mixer_data;
  logic          set_input_gain;
  logic          set_output_gain;
  logic          swap_pipelines;
  logic          current_pipeline;
  logic          ramping;
  logic          cmd_error;
  logic          swap_fault;

  int errors = 0;
  int checks = 0;
  int n_in   = 0;
  int n_out  = 0;
  int n_swap = 0;
  int n_err  = 0;
  logic [DW-1:0] exp_in_q[$];
  logic [DW-1:0] exp_out_q[$];

  mixer_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_op             (cmd_op),
    .cmd_data           (cmd_data),
    .sample_tick        (sample_tick),
    .pipelines_swapping (pipelines_swapping),
    .mixer_data         (mixer_data),
    .set_input_gain     (set_input_gain),
    .set_output_gain    (set_output_gain),
    .swap_pipelines     (swap_pipelines),
    .current_pipeline   (current_pipeline),
    .ramping            (ramping),
    .cmd_error          (cmd_error),
    .swap_fault         (swap_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every load strobe must match the next queued expected gain.
  always @(negedge clk) begin
    if (!reset) begin
      if (set_input_gain) begin
        n_in++;
        check("strobe_overlap", {31'd0, set_output_gain}, 32'd0);
        if (exp_in_q.size() == 0) check("unexpected_in_strobe", {31'd0, set_input_gain}, 32'd0);
        else check("in_gain_value", {16'd0, mixer_data}, {16'd0, exp_in_q.pop_front()});
      end
      if (set_output_gain) begin
        n_out++;
        if (exp_out_q.size() == 0) check("unexpected_out_strobe", {31'd0, set_output_gain}, 32'd0);
        else check("out_gain_value", {16'd0, mixer_data}, {16'd0, exp_out_q.pop_front()});
      end
      if (swap_pipelines) n_swap++;
      if (cmd_error) n_err++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic tick();
    step(1);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [DW-1:0] data);
    bit ok;
    step(1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    ok        = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin
        step(1);
        ok = 1'b1;
        break;
      end
      step(1);
    end
    cmd_valid = 1'b0;
    check($sformatf("accept_op%0d", op), {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    step(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    exp_in_q.delete();
    exp_out_q.delete();
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset              = 1'b1;
    cmd_valid          = 1'b0;
    cmd_op             = 2'd0;
    cmd_data           = '0;
    sample_tick        = 1'b0;
    pipelines_swapping = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);

    // Idle after reset: ticks with no commands produce no strobes.
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_ramping", {31'd0, ramping}, 32'd0);
    check("rst_mixer_data", {16'd0, mixer_data}, 32'd0);
    check("rst_pipeline", {31'd0, current_pipeline}, 32'd0);
    check("rst_swap_fault", {31'd0, swap_fault}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      step(3);
    end
    check("idle_in_strobes", n_in, 0);
    check("idle_out_strobes", n_out, 0);

    // Upward ramp 2048 -> 2100, last step clipped to the target.
    send(2'd0, 16'd2100);
    check("ramp_up_ramping_hi", {31'd0, ramping}, 32'd1);
    exp_in_q.push_back(16'd2064);
    exp_in_q.push_back(16'd2080);
    exp_in_q.push_back(16'd2096);
    exp_in_q.push_back(16'd2100);
    for (int k = 0; k < 4; k++) begin
      tick();
      step(4);
      if (k == 2) check("ramp_up_mid_ramping", {31'd0, ramping}, 32'd1);
    end
    check("ramp_up_done_ramping", {31'd0, ramping}, 32'd0);
    tick();
    step(4);
    tick();
    step(4);
    check("ramp_up_in_count", n_in, 4);
    check("ramp_up_out_count", n_out, 0);

    // Slot timing: input at tick+2, output at tick+3.
    do_reset();
    send(2'd0, 16'd2000);
    send(2'd1, 16'd0);
    exp_in_q.push_back(16'd2032);
    exp_out_q.push_back(16'd2032);
    tick();
    step(1);
    check("slot1_in", {31'd0, set_input_gain}, 32'd0);
    step(1);
    check("slot2_in", {31'd0, set_input_gain}, 32'd1);
    check("slot2_out", {31'd0, set_output_gain}, 32'd0);
    check("slot2_data", {16'd0, mixer_data}, 32'd2032);
    step(1);
    check("slot3_out", {31'd0, set_output_gain}, 32'd1);
    check("slot3_in", {31'd0, set_input_gain}, 32'd0);
    check("slot3_data", {16'd0, mixer_data}, 32'd2032);
    step(1);
    check("slot4_quiet", {30'd0, set_input_gain, set_output_gain}, 32'd0);

    // Paced swaps: second request held until the first completes.
    do_reset();
    base = n_swap;
    send(2'd2, '0);
    step(5);
    pipelines_swapping = 1'b1;
    step(20);
    check("swap1_count", n_swap - base, 1);
    check("swap1_pipeline", {31'd0, current_pipeline}, 32'd1);
    send(2'd2, '0);
    check("swap2_ready_low", {31'd0, cmd_ready}, 32'd0);
    step(270);
    check("swap2_held", n_swap - base, 1);
    pipelines_swapping = 1'b0;
    step(6);
    check("swap2_count", n_swap - base, 2);
    check("swap2_pipeline", {31'd0, current_pipeline}, 32'd0);
    check("swap2_ready_hi", {31'd0, cmd_ready}, 32'd1);
    check("swap2_no_fault", {31'd0, swap_fault}, 32'd0);

    // Swap timeout sets the sticky fault.
    do_reset();
    base = n_swap;
    send(2'd2, '0);
    for (int i = 0; i < 10; i++) begin
      if (n_swap != base) break;
      step(1);
    end
    check("tmo_pulse", n_swap - base, 1);
    step(250);
    check("tmo_not_yet", {31'd0, swap_fault}, 32'd0);
    step(10);
    check("tmo_fault", {31'd0, swap_fault}, 32'd1);
    check("tmo_ready", {31'd0, cmd_ready}, 32'd1);
    send(2'd1, 16'd1000);
    check("tmo_ramping", {31'd0, ramping}, 32'd1);
    step(20);
    check("tmo_sticky", {31'd0, swap_fault}, 32'd1);

    // Reset mid-ramp toward 0.
    do_reset();
    base = n_in;
    send(2'd0, 16'd0);
    exp_in_q.push_back(16'd2032);
    exp_in_q.push_back(16'd2016);
    exp_in_q.push_back(16'd2000);
    exp_in_q.push_back(16'd1984);
    for (int k = 0; k < 3; k++) begin
      tick();
      step(4);
    end
    check("down_count", n_in - base, 3);
    tick();
    step(2);
    check("down_4th_strobe", {31'd0, set_input_gain}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_strobe_clr", {31'd0, set_input_gain}, 32'd0);
    check("async_data_clr", {16'd0, mixer_data}, 32'd0);
    check("async_ready", {31'd0, cmd_ready}, 32'd1);
    step(2);
    reset = 1'b0;
    exp_in_q.delete();
    exp_out_q.delete();
    step(1);
    check("post_rst_ramping", {31'd0, ramping}, 32'd0);
    base = n_in;
    send(2'd0, 16'd2100);
    exp_in_q.push_back(16'd2064);
    tick();
    step(4);
    check("post_rst_step", n_in - base, 1);

    // Reserved op: one-cycle error pulse, nothing else changes.
    base = n_err;
    send(2'd3, 16'd5);
    check("err_pulse", {31'd0, cmd_error}, 32'd1);
    step(1);
    check("err_pulse_end", {31'd0, cmd_error}, 32'd0);
    check("err_count", n_err - base, 1);
    check("err_ready", {31'd0, cmd_ready}, 32'd1);
    check("err_ramping", {31'd0, ramping}, 32'd1);
    exp_in_q.push_back(16'd2080);
    tick();
    step(4);
    check("final_in_queue", exp_in_q.size(), 0);
    check("final_out_queue", exp_out_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
